direction_arbiter: RTL and testbench

DIRECTION_ARBITER -- requirements
Module: direction_arbiter

---
 rtl/direction_pkg.sv | 30 +++
 rtl/direction_timer.sv | 38 +++
 rtl/direction_arbiter.sv | 141 ++++++++++++++
 tb/tb_direction_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/direction_pkg.sv
// Shared types for the direction arbiter: direction encoding, FSM states,
// grant sources, and the counter width helper.
package direction_pkg;

    typedef enum logic [1:0] {
        FWD   = 2'b00,
        REV   = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } direc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        ACTIVE = 2'b10
    } arb_state_t;

    typedef enum logic {
        SRC_MAN  = 1'b0,
        SRC_AUTO = 1'b1
    } src_t;

    // Bits needed to hold the larger of the two cycle counts.
    function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
        int max_cycles;
        max_cycles = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/direction_timer.sv
// Loadable down counter with a zero flag. Saturates at zero; a load always
// wins over a decrement in the same cycle.
module direction_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load, else decrement unless already at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/direction_arbiter.sv
// Round-robin arbiter between a manual and an autonomous direction requester.
// An accepted direction is held for HOLD_CYCLES, then stays active until a new
// request arrives or TIMEOUT_CYCLES idle cycles pass. estop forces IDLE.
//
// Handshake: a request transfers on a rising clk edge where valid and ready
// are both high. ready is combinational, asserted only in IDLE/ACTIVE with
// estop low and reset released, and to at most one requester. A requester
// may drop valid without a transfer and keeps direc stable while valid.
module direction_arbiter
    import direction_pkg::*;
#(
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       estop,
    input  logic       man_valid,
    input  logic [1:0] man_direc,
    output logic       man_ready,
    input  logic       auto_valid,
    input  logic [1:0] auto_direc,
    output logic       auto_ready,
    output logic [1:0] direc,
    output logic       enable,
    output logic       grant_src,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t state_q, state_d;
    direc_t     direc_q, direc_d;
    logic       enable_q, enable_d;
    src_t       grant_src_q, grant_src_d;
    src_t       last_grant_q, last_grant_d;

    logic             can_accept;
    logic             pick_auto;
    logic             xfer;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_dec;
    logic             tmr_zero;

    direction_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    // Ready generation: single valid wins, on a tie the source not granted last.
    always_comb begin
        can_accept = rst_n && !estop && ((state_q == IDLE) || (state_q == ACTIVE));
        if (man_valid && auto_valid) begin
            pick_auto = (last_grant_q == SRC_MAN);
        end else begin
            pick_auto = auto_valid;
        end
        man_ready  = can_accept && man_valid && !pick_auto;
        auto_ready = can_accept && auto_valid && pick_auto;
        xfer       = man_ready || auto_ready;
    end

    // Next-state logic; estop beats a transfer, a transfer beats the timers.
    always_comb begin
        state_d      = state_q;
        direc_d      = direc_q;
        enable_d     = enable_q;
        grant_src_d  = grant_src_q;
        last_grant_d = last_grant_q;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        tmr_dec      = 1'b0;

        if (estop) begin
            state_d   = IDLE;
            enable_d  = 1'b0;
            tmr_load  = 1'b1;
            tmr_value = '0;
        end else if (xfer) begin
            state_d      = HOLD;
            enable_d     = 1'b1;
            direc_d      = auto_ready ? direc_t'(auto_direc) : direc_t'(man_direc);
            grant_src_d  = auto_ready ? SRC_AUTO : SRC_MAN;
            last_grant_d = auto_ready ? SRC_AUTO : SRC_MAN;
            tmr_load     = 1'b1;
            tmr_value    = HOLD_LOAD;
        end else begin
            case (state_q)
                HOLD: begin
                    if (tmr_zero) begin
                        state_d   = ACTIVE;
                        tmr_load  = 1'b1;
                        tmr_value = TIMEOUT_LOAD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (tmr_zero) begin
                        state_d  = IDLE;
                        enable_d = 1'b0;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and registered outputs; manual wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            direc_q      <= FWD;
            enable_q     <= 1'b0;
            grant_src_q  <= SRC_MAN;
            last_grant_q <= SRC_AUTO;
        end else begin
            state_q      <= state_d;
            direc_q      <= direc_d;
            enable_q     <= enable_d;
            grant_src_q  <= grant_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign direc     = direc_q;
    assign enable    = enable_q;
    assign grant_src = grant_src_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_direction_arbiter.sv
// Directed bench for direction_arbiter with HOLD_CYCLES=4, TIMEOUT_CYCLES=10.
// Inputs change 1 ns after a rising edge; outputs are sampled a further ns later.
module tb_direction_arbiter;
    import direction_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       estop;
    logic       man_valid;
    logic [1:0] man_direc;
    logic       man_ready;
    logic       auto_valid;
    logic [1:0] auto_direc;
    logic       auto_ready;
    logic [1:0] direc;
    logic       enable;
    logic       grant_src;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    direction_arbiter #(.HOLD_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .estop      (estop),
        .man_valid  (man_valid),
        .man_direc  (man_direc),
        .man_ready  (man_ready),
        .auto_valid (auto_valid),
        .auto_direc (auto_direc),
        .auto_ready (auto_ready),
        .direc      (direc),
        .enable     (enable),
        .grant_src  (grant_src),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        estop      = 1'b0;
        man_valid  = 1'b0;
        man_direc  = 2'b00;
        auto_valid = 1'b0;
        auto_direc = 2'b00;
        tick(2);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        estop      = 1'b0;
        man_valid  = 1'b1;
        man_direc  = 2'b11;
        auto_valid = 1'b1;
        auto_direc = 2'b10;
        tick(2);
        #1;
        checks++; if (man_ready !== 1'b0) begin errors++; $display("FAIL reset_man_ready got %b exp 0", man_ready); end
        checks++; if (auto_ready !== 1'b0) begin errors++; $display("FAIL reset_auto_ready got %b exp 0", auto_ready); end
        checks++; if (direc !== 2'b00) begin errors++; $display("FAIL reset_direc got %b exp 00", direc); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", enable); end
        checks++; if (grant_src !== 1'b0) begin errors++; $display("FAIL reset_grant_src got %b exp 0", grant_src); end
        checks++; if (dbg_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", dbg_state); end
        man_valid  = 1'b0;
        auto_valid = 1'b0;
        rst_n      = 1'b1;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        man_valid = 1'b1;
        man_direc = 2'b10;
        #1;
        checks++; if (man_ready !== 1'b1) begin errors++; $display("FAIL single_ready_c0 got %b exp 1", man_ready); end
        tick(1);
        man_valid = 1'b0;
        #1;
        checks++; if (enable !== 1'b1 || direc !== 2'b10) begin errors++; $display("FAIL single_c1 got en=%b dir=%b exp en=1 dir=10", enable, direc); end
        checks++; if (dbg_state !== 2'b01 || grant_src !== 1'b0) begin errors++; $display("FAIL single_c1_state got st=%b src=%b exp st=01 src=0", dbg_state, grant_src); end
        tick(3);
        checks++; if (dbg_state !== 2'b01) begin errors++; $display("FAIL single_c4_hold got %b exp 01", dbg_state); end
        tick(1);
        checks++; if (dbg_state !== 2'b10 || enable !== 1'b1) begin errors++; $display("FAIL single_c5_active got st=%b en=%b exp st=10 en=1", dbg_state, enable); end
        tick(9);
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL single_c14_enable got %b exp 1", enable); end
        tick(1);
        checks++; if (enable !== 1'b0 || direc !== 2'b10 || dbg_state !== 2'b00) begin errors++; $display("FAIL single_c15 got en=%b dir=%b st=%b exp en=0 dir=10 st=00", enable, direc, dbg_state); end
    endtask

    task automatic test_tie();
        do_reset();
        man_valid  = 1'b1;
        man_direc  = 2'b00;
        auto_valid = 1'b1;
        auto_direc = 2'b01;
        #1;
        checks++; if (man_ready !== 1'b1 || auto_ready !== 1'b0) begin errors++; $display("FAIL tie_first got man=%b auto=%b exp man=1 auto=0", man_ready, auto_ready); end
        tick(1);
        checks++; if (direc !== 2'b00 || grant_src !== 1'b0) begin errors++; $display("FAIL tie_first_dir got dir=%b src=%b exp dir=00 src=0", direc, grant_src); end
        tick(4);
        checks++; if (auto_ready !== 1'b1 || man_ready !== 1'b0) begin errors++; $display("FAIL tie_second got man=%b auto=%b exp man=0 auto=1", man_ready, auto_ready); end
        tick(1);
        man_valid  = 1'b0;
        auto_valid = 1'b0;
        checks++; if (direc !== 2'b01 || grant_src !== 1'b1 || dbg_state !== 2'b01) begin errors++; $display("FAIL tie_second_dir got dir=%b src=%b st=%b exp dir=01 src=1 st=01", direc, grant_src, dbg_state); end
    endtask

    task automatic test_hold_block();
        do_reset();
        man_valid = 1'b1;
        man_direc = 2'b11;
        tick(1);
        man_valid  = 1'b0;
        auto_valid = 1'b1;
        auto_direc = 2'b00;
        #1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (auto_ready !== 1'b0) begin errors++; $display("FAIL hold_block_c%0d got %b exp 0", i, auto_ready); end
            if (i < 4) tick(1);
        end
        tick(1);
        checks++; if (auto_ready !== 1'b1 || dbg_state !== 2'b10) begin errors++; $display("FAIL hold_release got ready=%b st=%b exp ready=1 st=10", auto_ready, dbg_state); end
        tick(1);
        auto_valid = 1'b0;
        checks++; if (direc !== 2'b00 || grant_src !== 1'b1) begin errors++; $display("FAIL hold_after got dir=%b src=%b exp dir=00 src=1", direc, grant_src); end
    endtask

    task automatic test_estop();
        do_reset();
        man_valid = 1'b1;
        man_direc = 2'b01;
        tick(1);
        man_valid = 1'b0;
        tick(1);
        estop     = 1'b1;
        man_valid = 1'b1;
        man_direc = 2'b10;
        #1;
        checks++; if (man_ready !== 1'b0) begin errors++; $display("FAIL estop_ready_hold got %b exp 0", man_ready); end
        tick(1);
        checks++; if (enable !== 1'b0 || dbg_state !== 2'b00 || direc !== 2'b01) begin errors++; $display("FAIL estop_stop got en=%b st=%b dir=%b exp en=0 st=00 dir=01", enable, dbg_state, direc); end
        checks++; if (man_ready !== 1'b0 || auto_ready !== 1'b0) begin errors++; $display("FAIL estop_ready_idle got man=%b auto=%b exp 0 0", man_ready, auto_ready); end
        tick(1);
        estop = 1'b0;
        #1;
        checks++; if (man_ready !== 1'b1) begin errors++; $display("FAIL estop_release_ready got %b exp 1", man_ready); end
        tick(1);
        man_valid = 1'b0;
        checks++; if (direc !== 2'b10 || enable !== 1'b1) begin errors++; $display("FAIL estop_release_dir got dir=%b en=%b exp dir=10 en=1", direc, enable); end
        tick(3);
        checks++; if (dbg_state !== 2'b01) begin errors++; $display("FAIL estop_rehold_c4 got %b exp 01", dbg_state); end
        tick(1);
        checks++; if (dbg_state !== 2'b10) begin errors++; $display("FAIL estop_rehold_c5 got %b exp 10", dbg_state); end
    endtask

    task automatic test_timeout_race();
        do_reset();
        man_valid = 1'b1;
        man_direc = 2'b00;
        tick(1);
        man_valid = 1'b0;
        tick(13);
        auto_valid = 1'b1;
        auto_direc = 2'b11;
        #1;
        checks++; if (auto_ready !== 1'b1 || enable !== 1'b1 || dbg_state !== 2'b10) begin errors++; $display("FAIL race_c14 got ready=%b en=%b st=%b exp 1 1 10", auto_ready, enable, dbg_state); end
        tick(1);
        auto_valid = 1'b0;
        checks++; if (enable !== 1'b1 || dbg_state !== 2'b01 || direc !== 2'b11) begin errors++; $display("FAIL race_c15 got en=%b st=%b dir=%b exp en=1 st=01 dir=11", enable, dbg_state, direc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        man_valid = 1'b1;
        man_direc = 2'b11;
        tick(1);
        man_valid = 1'b0;
        tick(5);
        auto_valid = 1'b1;
        auto_direc = 2'b01;
        rst_n      = 1'b0;
        #1;
        checks++; if (direc !== 2'b00 || enable !== 1'b0) begin errors++; $display("FAIL rstmid_out got dir=%b en=%b exp dir=00 en=0", direc, enable); end
        checks++; if (man_ready !== 1'b0 || auto_ready !== 1'b0 || dbg_state !== 2'b00) begin errors++; $display("FAIL rstmid_ready got man=%b auto=%b st=%b exp 0 0 00", man_ready, auto_ready, dbg_state); end
        tick(1);
        rst_n     = 1'b1;
        man_valid = 1'b1;
        man_direc = 2'b10;
        #1;
        checks++; if (man_ready !== 1'b1 || auto_ready !== 1'b0) begin errors++; $display("FAIL rstmid_tie got man=%b auto=%b exp man=1 auto=0", man_ready, auto_ready); end
        man_valid  = 1'b0;
        auto_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_hold_block();
        test_estop();
        test_timeout_race();
        test_reset_mid();
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
